// File: rtl/sequencer_card_pkg.sv
// Shared definitions for the sequencer card: width macros, phase bit
// indices, FSM state encodings and phase decode helpers.
`ifndef SEQUENCER_CARD_DEFS
`define SEQUENCER_CARD_DEFS
`define DATAWIDTH 16
`define CTRLWIDTH 7
`endif

package sequencer_card_pkg;

    // Bit positions inside the one-hot phase bus
    localparam int PH_FETCH_A = 0;
    localparam int PH_FETCH_B = 1;
    localparam int PH_FETCH_C = 2;
    localparam int PH_READ_A  = 3;
    localparam int PH_READ_B  = 4;
    localparam int PH_WRITE_B = 5;
    localparam int PH_BRANCH  = 6;

    // Phase states are numbered to match their phase bit, so P(k+1) = Pk + 1
    typedef enum logic [3:0] {
        S_P0    = 4'd0,
        S_P1    = 4'd1,
        S_P2    = 4'd2,
        S_P3    = 4'd3,
        S_P4    = 4'd4,
        S_P5    = 4'd5,
        S_P6    = 4'd6,
        S_IDLE  = 4'd7,
        S_HALT  = 4'd8,
        S_FAULT = 4'd9
    } state_e;

    function automatic logic is_phase(state_e s);
        return (s <= S_P6);
    endfunction

    function automatic logic [`CTRLWIDTH-1:0] phase_of(state_e s);
        logic [`CTRLWIDTH-1:0] p;
        p = '0;
        case (s)
            S_P0:    p[PH_FETCH_A] = 1'b1;
            S_P1:    p[PH_FETCH_B] = 1'b1;
            S_P2:    p[PH_FETCH_C] = 1'b1;
            S_P3:    p[PH_READ_A]  = 1'b1;
            S_P4:    p[PH_READ_B]  = 1'b1;
            S_P5:    p[PH_WRITE_B] = 1'b1;
            S_P6:    p[PH_BRANCH]  = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seq_stall_timer.sv
// Stall timer: counts consecutive not-ready cycles within one phase and
// flags expiry on the cycle that would push the count past STALL_MAX.
module seq_stall_timer #(
    parameter int STALL_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic ready_i,
    output logic expire_o
);

    localparam int CW = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear on any phase advance or outside phases; otherwise count stalls
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || ready_i)
            cnt_d = '0;
        else if (cnt_q != CW'(STALL_MAX))
            cnt_d = cnt_q + CW'(1);
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_o = active_i && !ready_i && (cnt_q == CW'(STALL_MAX));

endmodule

// File: rtl/sequencer_card.sv
// Instruction phase sequencer: walks seven one-hot phases per instruction,
// stalls on mem_ready, halts at instruction boundaries, faults on a stuck
// phase. Optional single-step support under macro SEQ_SINGLE_STEP_EN.
module sequencer_card
    import sequencer_card_pkg::*;
#(
    parameter int STALL_MAX = 15,
    parameter int ICNT_W    = `DATAWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  halt,
    input  logic                  step,
    input  logic                  mem_ready,
    output logic [`CTRLWIDTH-1:0] phase,
    output logic                  phase_start,
    output logic                  running,
    output logic                  halted,
    output logic                  fault,
    output logic [ICNT_W-1:0]     icnt
);

    state_e            state_q, state_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic              pstart_q, pstart_d;
    logic              expire;
    logic              go;

    seq_stall_timer #(.STALL_MAX(STALL_MAX)) u_stall (
        .clk      (clk),
        .rst      (rst),
        .active_i (is_phase(state_q)),
        .ready_i  (mem_ready),
        .expire_o (expire)
    );

    // halt dominates run when both are requested
    assign go = run && !halt;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_mode_q, step_mode_d;
`else
    logic unused_step;
    assign unused_step = step;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
`ifdef SEQ_SINGLE_STEP_EN
        step_mode_d = step_mode_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (step) begin
                    state_d     = S_P0;
                    step_mode_d = 1'b1;
                end else
`endif
                if (go) state_d = S_P0;
            end
            S_P0, S_P1, S_P2, S_P3, S_P4, S_P5: begin
                if (expire)         state_d = S_FAULT;
                else if (mem_ready) state_d = state_e'(state_q + 4'd1);
            end
            S_P6: begin
                if (expire) begin
                    state_d = S_FAULT;
                end else if (mem_ready) begin
                    icnt_d = icnt_q + ICNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
                    if (step_mode_q) begin
                        state_d     = S_HALT;
                        step_mode_d = 1'b0;
                    end else
`endif
                    state_d = go ? S_P0 : S_HALT;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        // first cycle of a phase is any cycle entered from a different state
        pstart_d = is_phase(state_d) && (state_d != state_q);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            icnt_q   <= '0;
            pstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            pstart_q <= pstart_d;
        end
    end

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step flag lives for one instruction only
    always_ff @(posedge clk) begin
        if (rst) step_mode_q <= 1'b0;
        else     step_mode_q <= step_mode_d;
    end
`endif

    assign phase       = phase_of(state_q);
    assign phase_start = pstart_q;
    assign running     = is_phase(state_q);
    assign halted      = (state_q == S_HALT);
    assign fault       = (state_q == S_FAULT);
    assign icnt        = icnt_q;

endmodule

// File: tb/tb_sequencer_card.sv
// Directed bench for sequencer_card (ICNT_W=4 so counter wrap is reachable).
module tb_sequencer_card;

    logic       clk = 1'b0;
    logic       rst, run, halt, step, mem_ready;
    logic [6:0] phase;
    logic       phase_start, running, halted, fault;
    logic [3:0] icnt;
    int         n_chk  = 0;
    int         n_pass = 0;

    sequencer_card #(.STALL_MAX(15), .ICNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .halt        (halt),
        .step        (step),
        .mem_ready   (mem_ready),
        .phase       (phase),
        .phase_start (phase_start),
        .running     (running),
        .halted      (halted),
        .fault       (fault),
        .icnt        (icnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Advance one edge; outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".phase"}, 32'(phase), 32'h0);
        chk({tag, ".ps"},    32'(phase_start), 32'h0);
        chk({tag, ".run"},   32'(running), 32'h0);
        chk({tag, ".hlt"},   32'(halted), 32'h0);
        chk({tag, ".flt"},   32'(fault), 32'h0);
        chk({tag, ".icnt"},  32'(icnt), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [6:0] one;
        one = 7'd1;
        rst = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        chk_zero("reset");

        // two full instructions back to back
        rst = 1'b0; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("walk%0d.phase", i), 32'(phase), 32'(one << (i % 7)));
            chk($sformatf("walk%0d.ps", i), 32'(phase_start), 32'h1);
        end
        chk("walk.icnt1", 32'(icnt), 32'h1);
        tick();
        chk("walk.icnt2", 32'(icnt), 32'h2);
        chk("walk.p0", 32'(phase), 32'h01);

        // halt raised in P2 lets the instruction finish
        tick(); tick();
        chk("halt.p2", 32'(phase), 32'h04);
        halt = 1'b1;
        for (int i = 3; i < 7; i++) begin
            tick();
            chk($sformatf("halt.p%0d", i), 32'(phase), 32'(one << i));
        end
        tick();
        chk("halt.halted", 32'(halted), 32'h1);
        chk("halt.phase", 32'(phase), 32'h0);
        chk("halt.icnt", 32'(icnt), 32'h3);
        chk("halt.running", 32'(running), 32'h0);
        tick();
        chk("halt.wins", 32'(halted), 32'h1);

        // five-cycle stall in P3
        halt = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stall.p3", 32'(phase), 32'h08);
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d.phase", i), 32'(phase), 32'h08);
            chk($sformatf("stall%0d.ps", i), 32'(phase_start), 32'h0);
        end
        mem_ready = 1'b1;
        tick();
        chk("stall.p4", 32'(phase), 32'h10);
        chk("stall.ps", 32'(phase_start), 32'h1);

        // stuck in P1 faults on the 16th stalled cycle
        for (int i = 0; i < 4; i++) tick();
        chk("flt.p1", 32'(phase), 32'h02);
        chk("flt.icnt", 32'(icnt), 32'h4);
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("flt.15.phase", 32'(phase), 32'h02);
        chk("flt.15.fault", 32'(fault), 32'h0);
        tick();
        chk("flt.16.fault", 32'(fault), 32'h1);
        chk("flt.16.phase", 32'(phase), 32'h0);
        chk("flt.16.running", 32'(running), 32'h0);
        for (int i = 0; i < 4; i++) begin
            run = i[0]; halt = ~i[0]; step = 1'b1; mem_ready = 1'b1;
            tick();
            step = 1'b0;
            chk($sformatf("flt.sticky%0d", i), 32'(fault), 32'h1);
        end
        rst = 1'b1;
        tick();
        chk_zero("flt.rst");

        // reach HALT with one instruction done
        rst = 1'b0; run = 1'b1; halt = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("stp.p6", 32'(phase), 32'h40);
        halt = 1'b1;
        tick();
        chk("stp.halted", 32'(halted), 32'h1);
        chk("stp.icnt0", 32'(icnt), 32'h1);
        step = 1'b1;
        tick();
        step = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        chk("stp.p0", 32'(phase), 32'h01);
        halt = 1'b0;
        for (int i = 1; i < 7; i++) begin
            tick();
            chk($sformatf("stp.p%0d", i), 32'(phase), 32'(one << i));
        end
        tick();
        chk("stp.end.halted", 32'(halted), 32'h1);
        chk("stp.end.phase", 32'(phase), 32'h0);
        chk("stp.end.icnt", 32'(icnt), 32'h2);
        run = 1'b0;
        tick();
        chk("stp.stay", 32'(halted), 32'h1);
`else
        chk("stp.ign.halted", 32'(halted), 32'h1);
        chk("stp.ign.phase", 32'(phase), 32'h0);
        tick();
        chk("stp.ign.icnt", 32'(icnt), 32'h1);
`endif

        // counter wrap at 4 bits, then reset mid-instruction
        rst = 1'b1; run = 1'b0; halt = 1'b0;
        tick();
        rst = 1'b0; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 106; i++) tick();
        chk("wrap.icnt15", 32'(icnt), 32'hf);
        chk("wrap.p0", 32'(phase), 32'h01);
        for (int i = 0; i < 7; i++) tick();
        chk("wrap.icnt0", 32'(icnt), 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("wrap.p4", 32'(phase), 32'h10);
        rst = 1'b1;
        tick();
        chk_zero("wrap.rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sequencer_card.md
SEQUENCER_CARD -- requirements
Module: sequencer_card

Interface
REQ-001 Parameter: STALL_MAX, 15, max consecutive cycles a phase may wait on mem_ready before fault.
REQ-002 Parameter: ICNT_W, 16, width of retired-instruction counter.
REQ-003 Port: clk  input  1  system clock from clock card; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: run  input  1  level request to start/continue execution.
REQ-006 Port: halt  input  1  level request to stop at next instruction boundary.
REQ-007 Port: step  input  1  single-cycle pulse: execute exactly one instruction (see Configuration).
REQ-008 Port: mem_ready  input  1  memory/ALU ready; low holds current phase.
REQ-009 Port: phase  output  7  one-hot phase: bit0 FETCH_A, 1 FETCH_B, 2 FETCH_C, 3 READ_A, 4 READ_B, 5 WRITE_B, 6 BRANCH.
REQ-010 Port: phase_start  output  1  high on first cycle of each phase only.
REQ-011 Port: running  output  1  high in any phase state.
REQ-012 Port: halted  output  1  high in HALT state.
REQ-013 Port: fault  output  1  high in FAULT state.
REQ-014 Port: icnt  output  ICNT_W  retired-instruction count.

Function
REQ-015 States: IDLE, P0..P6 (one per phase bit), HALT, FAULT; phase SHALL be all-zero in IDLE/HALT/FAULT.
REQ-016 IDLE or HALT with run=1 and halt=0 at edge N -> P0 at edge N+1, phase_start=1.
REQ-017 In Pk with mem_ready=1 -> P(k+1) next edge (k<6); mem_ready=0 -> stay in Pk, phase_start=0.
REQ-018 P6 completing with mem_ready=1: icnt increments by 1 (wraps to 0 at all-ones); next state P0 if run=1 and halt=0, else HALT.
REQ-019 halt asserted mid-instruction SHALL NOT abort; current instruction completes through P6 before HALT.
REQ-020 run and halt simultaneously: halt wins.
REQ-021 Stall counter clears on every phase change; counts cycles with mem_ready=0; when it would exceed STALL_MAX -> FAULT next edge.
REQ-022 FAULT is sticky; only rst exits it; run/halt/step ignored.
REQ-023 phase_start SHALL never be high two consecutive cycles in the same phase.

Reset
REQ-024 rst=1 at an edge: state IDLE, phase=0, phase_start=0, running=0, halted=0, fault=0, icnt=0, stall counter=0.
REQ-025 rst has priority over all inputs, including mid-instruction and in FAULT.

Configuration
REQ-026 Macro SEQ_SINGLE_STEP_EN defined: step pulse in IDLE or HALT -> P0 next edge, executes P0..P6 once, then HALT regardless of run; step while running ignored.
REQ-027 Macro SEQ_SINGLE_STEP_EN undefined: step port present but ignored; no single-step logic synthesized.

Structure
REQ-028 State encodings, phase bit indices and `DATAWIDTH/`CTRLWIDTH SHALL live in the shared definitions include file, not locally.
REQ-029 One sub-module, seq_stall_timer (stall counter + fault compare), SHALL be instantiated; remainder is a single FSM.

Verification
REQ-030 rst, then run=1, mem_ready=1 for 14 cycles -> phase walks 0x01..0x40 twice, icnt=2, phase_start every cycle.
REQ-031 Running, halt=1 asserted during P2 -> P3..P6 complete, HALT next, halted=1, icnt +1, phase=0.
REQ-032 In P3, mem_ready=0 for 5 cycles -> phase stays 0x08, phase_start low for those cycles, then advances to P4 when ready=1.
REQ-033 STALL_MAX=15, mem_ready=0 held in P1 -> fault=1 after 16 stalled cycles; run toggling has no effect until rst.
REQ-034 With SEQ_SINGLE_STEP_EN, from HALT with run=1, step pulse -> exactly 7 phases then HALT, icnt +1; without macro -> stays HALT.
REQ-035 icnt preloaded near all-ones via 2^ICNT_W-1 completed instructions (ICNT_W=4: 15) -> next completion gives icnt=0; rst during P4 -> IDLE, all outputs zero next edge.
